fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_addr  output  32  byte address to instruction memory (read on negedge, data valid by next posedge).
REQ-005 SHALL have port imem_rdata  input  32  instruction word returned for imem_addr.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-007 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-008 SHALL have port id_ready  input  1  decode stage can accept the IF/ID entry.
REQ-009 SHALL have port id_valid  output  1  IF/ID entry holds a valid instruction.
REQ-010 SHALL have port id_instr  output  32  captured instruction.
REQ-011 SHALL have port id_pc  output  32  address of id_instr.
REQ-012 SHALL have port id_pc_plus4  output  32  id_pc + 4, modulo 2^32.
REQ-013 SHALL have port fetch_count  output  32  number of instructions delivered to decode.

Function
REQ-014 SHALL hold fetch PC register pc; imem_addr SHALL equal pc combinationally.
REQ-015 SHALL implement FSM states BOOT, RUN (plus FAULT under REQ-028).
REQ-016 BOOT: id_valid=0, no capture (memory output stale); next state RUN; pc unchanged unless redirect.
REQ-017 RUN, redirect_valid=1: pc<=redirect_pc, id_valid<=0, no capture; other IF/ID fields hold.
REQ-018 RUN, no redirect, id_valid=1 and id_ready=0 (stall): pc, id_valid, id_instr, id_pc, id_pc_plus4 all hold.
REQ-019 RUN, no redirect, not stalled: id_instr<=imem_rdata, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
REQ-020 Priority: redirect > stall > advance; redirect during stall SHALL discard the stalled entry.
REQ-021 Redirect in BOOT SHALL load pc and still transition to RUN.
REQ-022 Capture latency: instruction at address A SHALL appear on id_instr one posedge after pc=A with no stall.
REQ-023 pc+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without fault.
REQ-024 fetch_count SHALL increment by 1 on each posedge where id_valid=1 and id_ready=1; wraps 2^32-1 -> 0.
REQ-025 Sustained throughput with id_ready=1 and no redirect SHALL be one instruction per cycle.

Reset
REQ-026 On resetn=0, immediately and regardless of clk: state=BOOT, pc=RESET_PC, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, id_pc_plus4=0, fetch_count=0.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL abandon all in-flight state; first capture occurs on the second posedge after resetn rises.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN defined: output port misalign_fault (1 bit, reset 0) SHALL exist; redirect with redirect_pc[1:0]!=0 SHALL enter FAULT, set misalign_fault=1, load pc=redirect_pc, id_valid=0; FAULT SHALL capture nothing; only an aligned redirect SHALL leave FAULT (to RUN, misalign_fault<=0); misaligned redirect in FAULT stays in FAULT.
REQ-029 Macro undefined: no misalign_fault port, no FAULT state; redirect_pc[1:0] SHALL be forced to 2'b00 when loaded into pc.

Verification
REQ-030 Reset release, id_ready=1, memory words W0..W3 at 0x0..0xC -> cycle 1 id_valid=0; cycles 2..5 id_pc=0x0,0x4,0x8,0xC, id_instr=W0..W3; fetch_count=4 after cycle 5.
REQ-031 id_ready=0 for 3 cycles while id_pc=0x8 -> id_pc=0x8, id_instr, pc=0xC stable all 3 cycles; fetch_count unchanged; resumes with 0xC.
REQ-032 redirect_valid=1, redirect_pc=0x40 while stalled at 0x8 -> next cycle id_valid=0; following cycle id_pc=0x40, id_pc_plus4=0x44.
REQ-033 RESET_PC=32'hFFFF_FFFC, no stall -> id_pc=0xFFFF_FFFC then 0x0000_0000, id_pc_plus4 of first entry=0x0.
REQ-034 resetn pulled low between clock edges mid-run -> all outputs at REQ-026 values before next posedge.
REQ-035 With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x42 -> misalign_fault=1, id_valid=0 for 4 cycles; then redirect_pc=0x80 -> misalign_fault=0, next cycle id_pc=0x80.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory port, the redirect input, the
// IF/ID entry and the delivered-instruction counter of fetch_unit.
//   master : the fetch unit (drives imem_addr and the IF/ID entry)
//   slave  : the environment (memory, branch resolution, decode stage)
// Optional feature macro FETCH_MISALIGN_TRAP_EN adds the misalign_fault signal.
interface fetch_unit_if;
  logic [31:0] imem_addr;      // byte address to instruction memory
  logic [31:0] imem_rdata;     // word returned for imem_addr
  logic        redirect_valid; // branch/jump taken: flush and refetch
  logic [31:0] redirect_pc;    // redirect target byte address
  logic        id_ready;       // decode can accept the IF/ID entry
  logic        id_valid;       // IF/ID entry holds a valid instruction
  logic [31:0] id_instr;       // captured instruction
  logic [31:0] id_pc;          // address of id_instr
  logic [31:0] id_pc_plus4;    // id_pc + 4, modulo 2^32
  logic [31:0] fetch_count;    // instructions delivered to decode
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_fault; // last redirect target was not word aligned

  modport master (
    output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fetch_count, misalign_fault,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fetch_count, misalign_fault,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
`else
  modport master (
    output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fetch_count,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fetch_count,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-entry instruction fetch stage. Holds the fetch PC, presents
// it to instruction memory, and captures the returned word into an IF/ID entry
// that decode consumes with a valid/ready handshake. Redirects flush the entry.
// Ports:
//   clk    : clock, all state updates on posedge
//   resetn : asynchronous active-low reset
//   bus    : fetch_unit_if.master (memory port, redirect, IF/ID entry, fetch_count)
// Parameter RESET_PC : fetch address loaded on reset.
// Macro FETCH_MISALIGN_TRAP_EN : when defined, a misaligned redirect enters a
// FAULT state and raises misalign_fault; otherwise redirect targets are forced
// word aligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         resetn,
  fetch_unit_if.master bus
);

  localparam logic [31:0] Nop = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {StBoot, StRun, StFault} state_e;
`else
  typedef enum logic [1:0] {StBoot, StRun} state_e;
`endif

  state_e      state_q;
  logic [31:0] pc_q;
  logic        id_valid_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_pc_plus4_q;
  logic [31:0] fetch_count_q;
  logic [31:0] redirect_tgt;
  logic        stall;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_fault_q;
  logic        misaligned;
  assign misaligned   = (bus.redirect_pc[1:0] != 2'b00);
  assign redirect_tgt = bus.redirect_pc;
  assign bus.misalign_fault = misalign_fault_q;
`else
  assign redirect_tgt = bus.redirect_pc & ~32'h0000_0003;
`endif

  assign stall = id_valid_q && !bus.id_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= StBoot;
      pc_q             <= RESET_PC;
      id_valid_q       <= 1'b0;
      id_instr_q       <= Nop;
      id_pc_q          <= 32'h0;
      id_pc_plus4_q    <= 32'h0;
      fetch_count_q    <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_fault_q <= 1'b0;
`endif
    end else begin
      // A delivery is the handshake on the current entry, whatever happens next.
      if (id_valid_q && bus.id_ready) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end

      unique case (state_q)
        // Memory output is stale on the first cycle out of reset: never capture.
        StBoot: begin
          id_valid_q <= 1'b0;
          state_q    <= StRun;
          if (bus.redirect_valid) begin
            pc_q <= redirect_tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
              state_q          <= StFault;
              misalign_fault_q <= 1'b1;
            end
`endif
          end
        end
        StRun: begin
          if (bus.redirect_valid) begin
            // Redirect wins over a stall: the stalled entry is discarded.
            pc_q       <= redirect_tgt;
            id_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
              state_q          <= StFault;
              misalign_fault_q <= 1'b1;
            end
`endif
          end else if (!stall) begin
            id_instr_q    <= bus.imem_rdata;
            id_pc_q       <= pc_q;
            id_pc_plus4_q <= pc_q + 32'd4;
            id_valid_q    <= 1'b1;
            pc_q          <= pc_q + 32'd4;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        StFault: begin
          id_valid_q <= 1'b0;
          if (bus.redirect_valid) begin
            pc_q <= redirect_tgt;
            if (!misaligned) begin
              state_q          <= StRun;
              misalign_fault_q <= 1'b0;
            end
          end
        end
`endif
        default: state_q <= StBoot;
      endcase
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc_plus4 = id_pc_plus4_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a stream-level model checked every cycle, plus
// hand-computed literal expectations at key points of a directed sequence.
// A second instance with RESET_PC = 32'hFFFF_FFFC exercises PC wrap.
module tb_fetch_unit;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if bus_w ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_w)
  );

  // Memory contents are a pure function of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign bus.imem_rdata       = word_at(bus.imem_addr);
  assign bus_w.imem_rdata     = word_at(bus_w.imem_addr);
  assign bus_w.redirect_valid = 1'b0;
  assign bus_w.redirect_pc    = 32'h0;
  assign bus_w.id_ready       = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stream model ----------------
  logic [31:0] m_fetch;    // next address to be fetched
  logic [31:0] m_instr;
  logic [31:0] m_addr;     // address of the entry held for decode
  logic [31:0] m_count;
  bit          m_full;     // entry holds a valid instruction
  bit          m_warm;     // first cycle after reset has passed
  bit          m_seen;     // an instruction has ever been captured since reset
  bit          m_fault;

  task automatic model_reset();
    m_fetch = 32'h0;
    m_instr = 32'h0000_0013;
    m_addr  = 32'h0;
    m_count = 32'h0;
    m_full  = 1'b0;
    m_warm  = 1'b0;
    m_seen  = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic model_edge(input bit rv, input logic [31:0] rpc, input bit rdy);
    if (m_full && rdy) m_count++;
    if (rv) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      m_fault = (rpc % 4) != 0;
      m_fetch = rpc;
`else
      m_fetch = rpc - (rpc % 4);
`endif
      m_full = 1'b0;
    end else if (!m_warm || m_fault) begin
      m_full = 1'b0;
    end else if (!(m_full && !rdy)) begin
      m_instr = word_at(m_fetch);
      m_addr  = m_fetch;
      m_full  = 1'b1;
      m_seen  = 1'b1;
      m_fetch = m_fetch + 4;
    end
    m_warm = 1'b1;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) model_reset();
    else model_edge(bus.redirect_valid, bus.redirect_pc, bus.id_ready);
    #1;
    check("m_imem_addr", bus.imem_addr, m_fetch);
    check("m_id_valid", {31'b0, bus.id_valid}, {31'b0, m_full});
    check("m_id_instr", bus.id_instr, m_instr);
    check("m_id_pc", bus.id_pc, m_addr);
    check("m_id_pc_plus4", bus.id_pc_plus4, m_seen ? m_addr + 32'd4 : 32'h0);
    check("m_fetch_count", bus.fetch_count, m_count);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("m_misalign_fault", {31'b0, bus.misalign_fault}, {31'b0, m_fault});
`endif
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("rst_imem_addr", bus.imem_addr, 32'h0);
    check("rst_id_instr", bus.id_instr, 32'h0000_0013);
    check("rst_wrap_addr", bus_w.imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    resetn = 1'b1;

    // Sustained fetch from address 0.
    step();
    check("a_boot_valid", {31'b0, bus.id_valid}, 32'h0);
    step();
    check("a_pc0", bus.id_pc, 32'h0);
    check("a_w0", bus.id_instr, 32'hFFFF_0000);
    check("a_pc0_plus4", bus.id_pc_plus4, 32'h4);
    check("wrap_pc", bus_w.id_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", bus_w.id_pc_plus4, 32'h0);
    step();
    check("a_pc4", bus.id_pc, 32'h4);
    check("a_w1", bus.id_instr, 32'hFFFB_0004);
    check("wrap_pc_next", bus_w.id_pc, 32'h0);
    check("wrap_instr_next", bus_w.id_instr, 32'hFFFF_0000);
    step();
    check("a_pc8", bus.id_pc, 32'h8);
    step();
    check("a_pcc", bus.id_pc, 32'hC);
    check("a_w3", bus.id_instr, 32'hFFF3_000C);
    step();
    check("a_count4", bus.fetch_count, 32'd4);

    // Asynchronous reset between edges.
    #2 resetn = 1'b0;
    #1;
    check("b_rst_valid", {31'b0, bus.id_valid}, 32'h0);
    check("b_rst_instr", bus.id_instr, 32'h0000_0013);
    check("b_rst_pc", bus.id_pc, 32'h0);
    check("b_rst_plus4", bus.id_pc_plus4, 32'h0);
    check("b_rst_count", bus.fetch_count, 32'h0);
    check("b_rst_addr", bus.imem_addr, 32'h0);
    step();
    resetn = 1'b1;

    // Stall at 0x8 for three cycles, then redirect while stalled.
    step();
    step();
    step();
    step();
    check("c_pc8", bus.id_pc, 32'h8);
    check("c_count2", bus.fetch_count, 32'd2);
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("c_stall_pc", bus.id_pc, 32'h8);
      check("c_stall_instr", bus.id_instr, 32'hFFF7_0008);
      check("c_stall_fetch", bus.imem_addr, 32'hC);
      check("c_stall_count", bus.fetch_count, 32'd2);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    step();
    check("c_redir_valid", {31'b0, bus.id_valid}, 32'h0);
    check("c_redir_addr", bus.imem_addr, 32'h40);
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
    step();
    check("c_pc40", bus.id_pc, 32'h40);
    check("c_pc40_plus4", bus.id_pc_plus4, 32'h44);
    check("c_w40", bus.id_instr, 32'hFFBF_0040);
    step();
    bus.id_ready = 1'b0;
    step();
    step();
    check("d_stall_pc", bus.id_pc, 32'h44);
    bus.id_ready = 1'b1;
    step();
    check("d_resume_pc", bus.id_pc, 32'h48);
    check("d_count", bus.fetch_count, 32'd4);

    // Misaligned redirect target.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    step();
    bus.redirect_valid = 1'b0;
    check("e_mis_valid", {31'b0, bus.id_valid}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("e_fault_addr", bus.imem_addr, 32'h42);
    for (int i = 0; i < 3; i++) begin
      step();
      check("e_fault_flag", {31'b0, bus.misalign_fault}, 32'h1);
      check("e_fault_valid", {31'b0, bus.id_valid}, 32'h0);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    step();
    bus.redirect_valid = 1'b0;
    check("e_fault_clear", {31'b0, bus.misalign_fault}, 32'h0);
    step();
    check("e_pc80", bus.id_pc, 32'h80);
`else
    check("e_aligned_addr", bus.imem_addr, 32'h40);
    step();
    check("e_pc40", bus.id_pc, 32'h40);
`endif

    // Reset mid-stall, then redirect during the boot cycle.
    bus.id_ready = 1'b0;
    step();
    step();
    #2 resetn = 1'b0;
    #1;
    check("f_rst_valid", {31'b0, bus.id_valid}, 32'h0);
    check("f_rst_count", bus.fetch_count, 32'h0);
    step();
    resetn             = 1'b1;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    check("f_boot_valid", {31'b0, bus.id_valid}, 32'h0);
    check("f_boot_addr", bus.imem_addr, 32'h100);
    step();
    check("f_first_valid", {31'b0, bus.id_valid}, 32'h1);
    check("f_first_pc", bus.id_pc, 32'h100);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
